matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter: COEF_W, 32, coefficient width in bits, signed two's complement.
REQ-002 Parameter: Q, 17, coefficient modulus used only when MATRIX_LOADER_MODQ_EN is defined.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: sync_clr  input  1  synchronous clear; abandons any partial or held frame.
REQ-006 Port: in_valid  input  1  in_coef and in_last are valid this cycle.
REQ-007 Port: in_ready  output  1  loader can accept a coefficient this cycle.
REQ-008 Port: in_coef  input  COEF_W  signed coefficient, stream order k = 0..15.
REQ-009 Port: in_last  input  1  marks the final (16th) coefficient of a frame.
REQ-010 Port: out_valid  output  1  matrix_out holds a complete frame.
REQ-011 Port: out_ready  input  1  downstream transpose stage consumes the frame.
REQ-012 Port: matrix_out  output  [3:0][3:0] x COEF_W signed  assembled 2x2 polynomial matrix (4 polys x 4 coefs), feeds the transpose stage.
REQ-013 Port: frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-014 Two states: FILL (collecting) and FULL (holding a frame for downstream).
REQ-015 A transfer occurs when in_valid and in_ready are both 1; in_ready = 1 in FILL, 0 in FULL and while rst is high.
REQ-016 A 4-bit counter cnt, 0..15, selects the write slot: coefficient k goes to matrix_out[k/4][k%4]; cnt increments per transfer.
REQ-017 A transfer with cnt = 15 and in_last = 1 writes slot [3][3], clears cnt to 0 and enters FULL; out_valid = 1 on the next cycle, giving 1-cycle latency from the last transfer.
REQ-018 A transfer with in_last = 1 and cnt != 15, or with cnt = 15 and in_last = 0, pulses frame_err for exactly one cycle, clears cnt to 0, stays in FILL, and discards the partial frame.
REQ-019 In FULL, out_valid = 1 and matrix_out stays constant until out_valid and out_ready are both 1; that cycle returns to FILL, and in_ready = 1 on the following cycle.
REQ-020 out_ready is ignored in FILL; in_valid is ignored in FULL.
REQ-021 sync_clr = 1 has priority over every other event: next state FILL, cnt = 0, out_valid = 0, no frame_err pulse; matrix_out contents are not cleared.
REQ-022 sync_clr coincident with the 16th transfer drops that frame: no out_valid and no frame_err.
REQ-023 Outputs are registered; there is no combinational path from in_coef to matrix_out.

Reset
REQ-024 While rst is high: state = FILL, cnt = 0, every matrix_out element = 0, out_valid = 0, frame_err = 0, in_ready = 0.
REQ-025 Reset asserted mid-frame discards all partial data; the first transfer after rst deasserts is coefficient k = 0.

Configuration
REQ-026 Macro MATRIX_LOADER_MODQ_EN defined: each stored coefficient = in_coef mod Q, normalised to 0..Q-1, with negatives wrapped (e.g. -1 -> 16).
REQ-027 Macro MATRIX_LOADER_MODQ_EN undefined: in_coef is stored verbatim and no reduction logic is instantiated; the Q parameter is unused.

Verification
REQ-028 Stream 0..15, in_last on 15, out_ready = 1 -> out_valid the cycle after the last transfer; matrix_out[1][2] = 6 and [3][3] = 15; in_ready low for exactly one cycle.
REQ-029 Full frame, then out_ready = 0 for 5 cycles -> out_valid stays 1, in_ready stays 0, matrix_out is unchanged; raise out_ready -> handshake occurs, in_ready = 1 on the next cycle.
REQ-030 in_last on the 7th coefficient -> frame_err pulses once; the next 16 coefficients 100..115 yield matrix_out[0][0] = 100.
REQ-031 Assert rst after 9 transfers -> out_valid = 0 and matrix_out all zero; the following full frame is assembled correctly.
REQ-032 sync_clr on the 16th transfer -> no out_valid and no frame_err; the next frame completes normally.
REQ-033 With the macro defined, in_coef = -1 stores 16 and in_coef = 35 stores 1; without the macro, -1 stores 32'hFFFFFFFF.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: collects a stream of 16 signed coefficients into a 4x4
// coefficient matrix (four polynomials of four coefficients each, forming a
// 2x2 polynomial matrix). The matrix is then held for a downstream
// transpose stage.
//
// Optional feature: when MATRIX_LOADER_MODQ_EN is defined, each coefficient is
// reduced mod Q into 0..Q-1 before it is stored. Otherwise it is stored
// verbatim.
//
// Ports:
//   clk         clock; all state updates on its rising edge
//   rst         asynchronous active-high reset
//   sync_clr    synchronous clear; drops any partial or held frame
//   in_valid    in_coef/in_last valid
//   in_ready    loader accepts a coefficient this cycle
//   in_coef     signed coefficient, stream order k = 0..15
//   in_last     marks the 16th coefficient of a frame
//   out_valid   matrix_out holds a complete frame
//   out_ready   downstream consumes the frame
//   matrix_out  [poly][coef] assembled matrix, coefficient k at [k/4][k%4]
//   frame_err   one-cycle pulse on a framing violation
module matrix_loader #(
  parameter int COEF_W = 32,
  parameter int Q      = 17
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sync_clr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [COEF_W-1:0]            in_coef,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [3:0][3:0][COEF_W-1:0]  matrix_out,
  output logic                                frame_err
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_d;
  logic                    xfer;
  logic                    wr_en;
  logic signed [COEF_W-1:0] store_val;

  // in_ready also drops while rst is high, not just from the reset state.
  assign in_ready  = (state_q == ST_FILL) && !rst;
  assign out_valid = (state_q == ST_FULL);
  assign xfer      = in_valid && in_ready;
  // A cleared transfer is dropped, so it is not written.
  assign wr_en     = xfer && !sync_clr;

`ifdef MATRIX_LOADER_MODQ_EN
  localparam logic signed [COEF_W-1:0] QS = COEF_W'(Q);
  logic signed [COEF_W-1:0] rem;

  // Signed % follows the sign of the dividend, so wrap negative remainders.
  always_comb begin
    rem = in_coef % QS;
    if (rem < 0) begin
      rem = rem + QS;
    end
    store_val = rem;
  end
`else
  assign store_val = in_coef;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (sync_clr) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end else if (state_q == ST_FULL) begin
      if (out_ready) begin
        state_d = ST_FILL;
      end
    end else if (xfer) begin
      if (cnt_q == 4'd15 && in_last) begin
        cnt_d   = '0;
        state_d = ST_FULL;
      end else if (cnt_q == 4'd15 || in_last) begin
        // Early or missing in_last: the partial frame is abandoned.
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      frame_err  <= 1'b0;
      matrix_out <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_err <= err_d;
      if (wr_en) begin
        matrix_out[cnt_q[3:2]][cnt_q[1:0]] <= store_val;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: directed scenarios plus randomized traffic, all
// checked every cycle against a frame-level reference model (a queue of
// accepted coefficients).
module tb_matrix_loader;

  localparam int W  = 32;
  localparam int MW = 16 * W;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          sync_clr;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [W-1:0]           in_coef;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [3:0][3:0][W-1:0] matrix_out;
  logic                          frame_err;

  matrix_loader #(.COEF_W(W), .Q(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_clr   (sync_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_coef    (in_coef),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .matrix_out (matrix_out),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0]         frame[$];
  logic [3:0][3:0][W-1:0] exp_mat;
  logic                 exp_valid;
  logic                 exp_err;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] store(input logic [W-1:0] c);
`ifdef MATRIX_LOADER_MODQ_EN
    int r;
    r = $signed(c) % 17;
    if (r < 0) r += 17;
    return W'(r);
`else
    return c;
`endif
  endfunction

  task automatic check_outputs();
    check("in_ready", MW'(in_ready), MW'(!exp_valid && !rst));
    check("out_valid", MW'(out_valid), MW'(exp_valid));
    check("frame_err", MW'(frame_err), MW'(exp_err));
    if (exp_valid) check("matrix", matrix_out, exp_mat);
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, check at the next falling edge.
  task automatic cycle(input logic v, input logic last, input logic [W-1:0] coef,
                       input logic sclr, input logic ordy);
    logic xfer;
    in_valid  = v;
    in_last   = last;
    in_coef   = coef;
    sync_clr  = sclr;
    out_ready = ordy;
    @(posedge clk);
    xfer    = v && !exp_valid;
    exp_err = 1'b0;
    if (sclr) begin
      frame.delete();
      exp_valid = 1'b0;
    end else if (exp_valid) begin
      if (ordy) exp_valid = 1'b0;
    end else if (xfer) begin
      frame.push_back(store(coef));
      if (last || frame.size() == 16) begin
        if (last && frame.size() == 16) begin
          for (int k = 0; k < 16; k++) exp_mat[k / 4][k % 4] = frame[k];
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        frame.delete();
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_frame(input int base, input logic ordy);
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 15, W'(base + i), 1'b0, ordy);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, ordy);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    frame.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    check("rst_in_ready", MW'(in_ready), MW'(0));
    check("rst_out_valid", MW'(out_valid), MW'(0));
    check("rst_frame_err", MW'(frame_err), MW'(0));
    check("rst_matrix", matrix_out, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] m1;
    logic [W-1:0] c35;
    int sz;
    rst = 1'b1; sync_clr = 0; in_valid = 0; in_last = 0; in_coef = '0; out_ready = 0;
    frame.delete(); exp_mat = '0; exp_valid = 0; exp_err = 0;
    @(negedge clk);
    apply_reset();

    // Ordered stream 0..15 with immediate consumption.
    send_frame(0, 1'b1);
    check("m12_is_6", MW'(matrix_out[1][2]), MW'(store(W'(6))));
    check("m33_is_15", MW'(matrix_out[3][3]), MW'(store(W'(15))));
    idle(2, 1'b1);

    // Backpressure: frame held for 5 cycles, in_valid ignored meanwhile.
    send_frame(200, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(999), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Early in_last on the 7th coefficient, then a clean frame.
    for (int i = 0; i < 7; i++) cycle(1'b1, i == 6, W'(50 + i), 1'b0, 1'b0);
    send_frame(100, 1'b0);
    check("m00_is_100", MW'(matrix_out[0][0]), MW'(store(W'(100))));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Missing in_last on the 16th coefficient.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, W'(i), 1'b0, 1'b0);
    idle(1, 1'b0);

    // Reset after 9 transfers, then a full frame.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, W'(70 + i), 1'b0, 1'b0);
    apply_reset();
    send_frame(300, 1'b1);
    idle(1, 1'b1);

    // sync_clr coincident with the 16th transfer drops the frame.
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 15, W'(400 + i), i == 15, 1'b0);
    idle(2, 1'b0);
    send_frame(500, 1'b1);
    idle(1, 1'b1);

    // Storage of negative and out-of-range values.
    m1 = '1;
    c35 = W'(35);
    cycle(1'b1, 1'b0, m1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, c35, 1'b0, 1'b0);
    for (int i = 2; i < 16; i++) cycle(1'b1, i == 15, W'(i), 1'b0, 1'b0);
`ifdef MATRIX_LOADER_MODQ_EN
    check("neg1_store", MW'(matrix_out[0][0]), MW'(16));
    check("c35_store", MW'(matrix_out[0][1]), MW'(1));
`else
    check("neg1_store", MW'(matrix_out[0][0]), MW'(32'hFFFF_FFFF));
    check("c35_store", MW'(matrix_out[0][1]), MW'(35));
`endif
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      sz = frame.size();
      cycle(($urandom % 4) != 0,
            (sz == 15) ? (($urandom % 8) != 0) : (($urandom % 20) == 0),
            W'($urandom),
            ($urandom % 64) == 0,
            ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
